// File: rtl/wb_uart_tx.sv
// Wishbone-attached UART transmitter: an 8N1 serialiser fed by a byte FIFO.
// It also exposes status and baud-divisor registers.
module wb_uart_tx #(
    parameter int CLK_FREQ   = 25_000_000,
    parameter int BAUDRATE   = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] wb_addr_i,
    input  logic [31:0] wb_wdata_i,
    output logic [31:0] wb_rdata_o,
    input  logic        wb_wr_en_i,
    input  logic [3:0]  wb_byte_en_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    output logic        ser_tx_o
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [15:0] DIV_RST = 16'(CLK_FREQ / BAUDRATE);
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   level_q, level_d;
    logic          ovf_q, ovf_d, ack_q, ack_d;
    logic [15:0]   clkdiv_q, clkdiv_d, div_new;
    logic [31:0]   rdata_q, rdata_d, status;

    state_e        state_q;
    logic [15:0]   timer_q, bitdiv_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic          ser_tx_q;

    logic          full, empty, busy, pop, req, wr, rd, push, push_ok;
    logic [1:0]    sel;
    logic          unused_bits;

    assign full    = (level_q == DEPTH_L);
    assign empty   = (level_q == '0);
    assign busy    = (state_q != IDLE);
    assign pop     = (state_q == IDLE) && !empty;
    assign req     = wb_stb_i & wb_cyc_i & ~ack_q;
    assign wr      = req & wb_wr_en_i;
    assign rd      = req & ~wb_wr_en_i;
    assign sel     = wb_addr_i[3:2];
    assign push    = wr && (sel == 2'd0) && wb_byte_en_i[0];
    // FULL is judged on the pre-pop level, so a push into a full FIFO drops even if a pop happens now
    assign push_ok = push && !full;
    assign status  = {20'b0, 4'(level_q), 4'b0, ovf_q, busy, empty, full};
    assign unused_bits = ^{wb_addr_i[31:4], wb_addr_i[1:0], wb_wdata_i[31:16], wb_byte_en_i[3:2]};

    always_comb begin
        mem_d    = mem_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        ovf_d    = ovf_q;
        clkdiv_d = clkdiv_q;
        div_new  = clkdiv_q;
        ack_d    = req;
        rdata_d  = '0;
        if (push_ok) begin
            mem_d[wptr_q] = wb_wdata_i[7:0];
            wptr_d        = wptr_q + AW'(1);
        end
        if (push && full)
            ovf_d = 1'b1;
        if (pop)
            rptr_d = rptr_q + AW'(1);
        level_d = level_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
        if (wr && sel == 2'd1 && wb_byte_en_i[0] && wb_wdata_i[3])
            ovf_d = 1'b0;
        if (wr && sel == 2'd2) begin
            if (wb_byte_en_i[0]) div_new[7:0]  = wb_wdata_i[7:0];
            if (wb_byte_en_i[1]) div_new[15:8] = wb_wdata_i[15:8];
            clkdiv_d = (div_new == 16'd0) ? 16'd1 : div_new;
        end
        if (rd) begin
            case (sel)
                2'd1:    rdata_d = status;
                2'd2:    rdata_d = {16'b0, clkdiv_q};
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '0};
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            clkdiv_q <= DIV_RST;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            clkdiv_q <= clkdiv_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
        end
    end

    // Divisor is captured per frame so a mid-frame CLKDIV write only affects the next frame
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            bitdiv_q <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            ser_tx_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: if (pop) begin
                    shift_q  <= mem_q[rptr_q];
                    bitdiv_q <= clkdiv_q;
                    timer_q  <= clkdiv_q - 16'd1;
                    ser_tx_q <= 1'b0;
                    state_q  <= START;
                end
                START: if (timer_q == '0) begin
                    timer_q  <= bitdiv_q - 16'd1;
                    idx_q    <= '0;
                    ser_tx_q <= shift_q[0];
                    state_q  <= DATA;
                end else timer_q <= timer_q - 16'd1;
                DATA: if (timer_q == '0) begin
                    timer_q <= bitdiv_q - 16'd1;
                    if (idx_q == 3'd7) begin
                        ser_tx_q <= 1'b1;
                        state_q  <= STOP;
                    end else begin
                        idx_q    <= idx_q + 3'd1;
                        shift_q  <= shift_q >> 1;
                        ser_tx_q <= shift_q[1];
                    end
                end else timer_q <= timer_q - 16'd1;
                STOP: if (timer_q == '0) state_q <= IDLE;
                      else timer_q <= timer_q - 16'd1;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wb_ack_o   = ack_q;
    assign wb_rdata_o = rdata_q;
    assign ser_tx_o   = ser_tx_q;
endmodule

// File: tb/tb_wb_uart_tx.sv
// Directed bench for wb_uart_tx: Wishbone register accesses plus a line
// monitor that decodes frames against a queue of expected bytes.
module tb_wb_uart_tx;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] wb_addr_i = '0;
    logic [31:0] wb_wdata_i = '0;
    logic [31:0] wb_rdata_o;
    logic        wb_wr_en_i = 1'b0;
    logic [3:0]  wb_byte_en_i = '0;
    logic        wb_stb_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_ack_o;
    logic        ser_tx_o;

    always #5 clk_i = ~clk_i;

    wb_uart_tx dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .wb_addr_i(wb_addr_i), .wb_wdata_i(wb_wdata_i), .wb_rdata_o(wb_rdata_o),
        .wb_wr_en_i(wb_wr_en_i), .wb_byte_en_i(wb_byte_en_i),
        .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_ack_o(wb_ack_o),
        .ser_tx_o(ser_tx_o)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] sb[$];
    int         cur_div = 217;
    bit         mon_busy = 1'b0;
    int         frames = 0;
    int         m_div;
    logic [9:0] m_bits;
    bit         m_ok, m_abort;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wb_acc(input logic [31:0] a, input logic we, input logic [31:0] d,
                          input logic [3:0] be, output logic [31:0] rdat);
        @(posedge clk_i); #1;
        wb_addr_i = a; wb_wr_en_i = we; wb_wdata_i = d; wb_byte_en_i = be;
        wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
        @(posedge clk_i); #1;
        chk("ack", {31'b0, wb_ack_o}, 32'd1);
        rdat = wb_rdata_o;
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_wr_en_i = 1'b0;
    endtask

    task automatic wb_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] dummy;
        wb_acc(a, 1'b1, d, be, dummy);
    endtask

    task automatic wb_rd(input logic [31:0] a, output logic [31:0] d);
        wb_acc(a, 1'b0, 32'd0, 4'hf, d);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((sb.size() != 0 || mon_busy) && n < budget) begin
            @(posedge clk_i);
            n++;
        end
        chk("drain_timeout", {31'b0, (n < budget)}, 32'd1);
        repeat (3) @(posedge clk_i);
    endtask

    // Line monitor: every bit slot must hold its value for the whole divisor period
    initial forever begin
        @(negedge clk_i);
        if (!rst_i && ser_tx_o === 1'b0) begin
            mon_busy = 1'b1;
            m_div = cur_div; m_ok = 1'b1; m_abort = 1'b0; m_bits = '0;
            for (int b = 0; b < 10; b++) begin
                for (int c = 0; c < m_div; c++) begin
                    if (!(b == 0 && c == 0)) @(negedge clk_i);
                    if (rst_i) m_abort = 1'b1;
                    if (c == 0) m_bits[b] = ser_tx_o;
                    else if (ser_tx_o !== m_bits[b]) m_ok = 1'b0;
                end
            end
            if (!m_abort) begin
                chk("frame_shape", {31'b0, m_ok && !m_bits[0] && m_bits[9]}, 32'd1);
                if (sb.size() == 0) chk("unexpected_frame", {24'b0, m_bits[8:1]}, 32'hffff_ffff);
                else chk("frame_byte", {24'b0, m_bits[8:1]}, {24'b0, sb.pop_front()});
                frames++;
            end
            mon_busy = 1'b0;
        end
    end

    initial begin
        logic [31:0] d;
        int lows;
        int frames_at_rst;

        repeat (3) @(negedge clk_i);
        chk("rst_ser", {31'b0, ser_tx_o}, 32'd1);
        chk("rst_ack", {31'b0, wb_ack_o}, 32'd0);
        chk("rst_rdata", wb_rdata_o, 32'd0);
        @(posedge clk_i); #1 rst_i = 1'b0;
        wb_rd(32'h4, d); chk("status_rst", d, 32'h2);
        wb_rd(32'h8, d); chk("clkdiv_rst", d, 32'd217);

        // single byte, start bit right after the ack edge
        wb_wr(32'h8, 32'd4, 4'h3); cur_div = 4;
        wb_rd(32'h8, d); chk("clkdiv_4", d, 32'd4);
        sb.push_back(8'hA5);
        wb_wr(32'h0, 32'hA5, 4'h1);
        @(negedge clk_i); chk("line_before_pop", {31'b0, ser_tx_o}, 32'd1);
        @(negedge clk_i); chk("line_after_pop", {31'b0, ser_tx_o}, 32'd0);
        drain(1000);
        wb_rd(32'h4, d); chk("status_idle", d, 32'h2);

        wb_rd(32'h0, d); chk("txdata_read", d, 32'h0);
        wb_wr(32'hC, 32'hffff_ffff, 4'hf);
        wb_rd(32'hC, d); chk("reserved_read", d, 32'h0);
        wb_rd(32'h8, d); chk("clkdiv_after_rsvd", d, 32'd4);
        wb_wr(32'h0, 32'h77, 4'h2);
        wb_rd(32'h4, d); chk("txdata_be_off", d, 32'h2);

        // overflow
        wb_wr(32'h8, 32'd100, 4'h3); cur_div = 100;
        for (int i = 0; i < 10; i++) begin
            if (i < 9) sb.push_back(8'(i));
            wb_wr(32'h0, 32'(i), 4'h1);
        end
        wb_rd(32'h4, d); chk("status_ovf", d, 32'h80D);
        wb_wr(32'h4, 32'h8, 4'h1);
        wb_rd(32'h4, d); chk("status_ovf_clr", d, 32'h805);
        drain(15000);
        wb_rd(32'h4, d); chk("status_drained", d, 32'h2);

        // divisor zero maps to one
        wb_wr(32'h8, 32'd0, 4'h3);
        wb_rd(32'h8, d); chk("clkdiv_zero", d, 32'd1);
        cur_div = 1;
        sb.push_back(8'h55);
        wb_wr(32'h0, 32'h55, 4'h1);
        drain(200);

        // mid-frame divisor change applies to the following frame only
        wb_wr(32'h8, 32'd3, 4'h3); cur_div = 3;
        sb.push_back(8'h33);
        wb_wr(32'h0, 32'h33, 4'h1);
        wb_wr(32'h8, 32'd6, 4'h3); cur_div = 6;
        sb.push_back(8'h0F);
        wb_wr(32'h0, 32'h0F, 4'h1);
        drain(500);
        wb_wr(32'h8, 32'h1234, 4'h1);
        wb_rd(32'h8, d); chk("clkdiv_be0", d, 32'h34);

        // reset during DATA with bytes queued
        wb_wr(32'h8, 32'd20, 4'h3); cur_div = 20;
        for (int i = 0; i < 3; i++) wb_wr(32'h0, 32'h0, 4'h1);
        repeat (40) @(posedge clk_i);
        #2 chk("line_in_data", {31'b0, ser_tx_o}, 32'd0);
        frames_at_rst = frames;
        rst_i = 1'b1;
        #1 chk("rst_async_line", {31'b0, ser_tx_o}, 32'd1);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        sb.delete();
        wb_rd(32'h4, d); chk("status_after_rst", d, 32'h2);
        wb_rd(32'h8, d); chk("clkdiv_after_rst", d, 32'd217);
        lows = 0;
        repeat (400) begin
            @(negedge clk_i);
            if (ser_tx_o !== 1'b1) lows++;
        end
        chk("no_frame_after_rst", 32'(lows), 32'd0);
        chk("frames_after_rst", 32'(frames), 32'(frames_at_rst));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/wb_uart_tx.md
# wb_uart_tx

Wishbone slave that sits directly downstream of the SoC's Wishbone output port (`wb_*_o` / `wb_*_i` of the OBI-to-WB path). It accepts byte writes from the core into an 8-entry transmit FIFO and serialises them on a UART line in 8N1 format at a programmable baud rate. It also exposes status and divisor registers, which gives firmware and benches a console output path.

## Interface
Parameters:
- `CLK_FREQ`, 25_000_000, core clock frequency in Hz.
- `BAUDRATE`, 115200, reset baud rate; the reset divisor is `CLK_FREQ/BAUDRATE` (integer division, 217 with the defaults).
- `FIFO_DEPTH`, 8, TX FIFO entries; must be a power of two, at least 2.

Ports (one clock `clk_i`; reset `rst_i` is asynchronous and active-high):
- `clk_i`  in  1  core clock.
- `rst_i`  in  1  asynchronous active-high reset.
- `wb_addr_i`  in  32  byte address; only bits [3:2] are decoded.
- `wb_wdata_i`  in  32  write data.
- `wb_rdata_o`  out  32  read data; valid only while `wb_ack_o`=1, otherwise 0.
- `wb_wr_en_i`  in  1  1 = write, 0 = read.
- `wb_byte_en_i`  in  4  byte enables.
- `wb_stb_i`  in  1  strobe.
- `wb_cyc_i`  in  1  cycle.
- `wb_ack_o`  out  1  acknowledge.
- `ser_tx_o`  out  1  UART TX line; idles high.

## Operation
Register map (word offset via `wb_addr_i[3:2]`):
- 0x0 TXDATA, write-only.
  - A write with `wb_byte_en_i[0]`=1 pushes `wb_wdata_i[7:0]`.
  - If the FIFO is full, the byte is dropped and OVF is set.
  - Reads return 0.
- 0x4 STATUS, read.
  - Bit 0 FULL; bit 1 EMPTY; bit 2 BUSY (transmitter not IDLE); bit 3 OVF (sticky).
  - Bits [11:8] hold the FIFO level, 0..FIFO_DEPTH.
  - A write with `wb_byte_en_i[0]`=1 and `wb_wdata_i[3]`=1 clears OVF. Other written bits are ignored.
- 0x8 CLKDIV, read/write, 16 bits in [15:0].
  - Byte enables [1:0] are honoured.
  - A resulting value of 0 is stored as 1.
  - Reads return the value zero-extended.
- 0xC reserved. Reads return 0; writes are ignored.

Wishbone access:
- Every access is accepted; there are no error or stall responses.
- The access takes effect on the same clock edge that raises the ack.

Transmitter FSM (IDLE, START, DATA, STOP):
- **IDLE:** if the FIFO is not empty, pop the head into the shift register, latch CLKDIV into the bit timer, load the timer with CLKDIV-1, and go to START.
- **START:** `ser_tx_o`=0 for CLKDIV cycles, then go to DATA with bit index 0.
- **DATA:** `ser_tx_o` = shift[index], LSB first, CLKDIV cycles per bit. After bit 7, go to STOP.
- **STOP:** `ser_tx_o`=1 for CLKDIV cycles, then go to IDLE.
- A CLKDIV write mid-frame affects only the next frame.

FIFO:
- Circular buffer with read and write pointers that wrap, plus a level counter.
- FULL is evaluated before any same-cycle pop. A push while FULL is dropped even if a pop occurs in the same cycle.
- A push to a non-full FIFO concurrent with a pop leaves the level unchanged.

## Timing
Reset values:
- `wb_ack_o`=0, `wb_rdata_o`=0, `ser_tx_o`=1.
- FIFO empty (level 0), OVF=0, FSM in IDLE, CLKDIV=`CLK_FREQ/BAUDRATE`.

Reset mid-frame:
- `ser_tx_o` returns high immediately (asynchronous).
- FIFO contents are discarded.

Wishbone ack:
- `wb_ack_o` rises on the edge after `wb_stb_i & wb_cyc_i & !wb_ack_o` is sampled, and stays high for exactly 1 cycle.
- Back-to-back accesses therefore complete at most every 2 cycles.
- If `wb_cyc_i` drops before the ack, the access is abandoned with no side effect only when the request was not yet sampled.

Transmit latency:
- TXDATA write sampled at edge E0 → FIFO updated at E0.
- IDLE pops at E1, and `ser_tx_o` falls after E1.
- Frame length is 10×CLKDIV cycles. IDLE occupies 1 cycle between frames, so back-to-back frames repeat every 10×CLKDIV+1 cycles.

FSM count:
- BUSY is high from the pop edge through the last STOP cycle.
- The bit timer is 16 bits and counts down from CLKDIV-1 to 0. The state or bit advances on 0.

## Test plan
- **Reset:** assert `rst_i` → `ser_tx_o`=1, `wb_ack_o`=0, STATUS reads 0x0000_0002, CLKDIV reads 217 (0x00D9).
- **Single byte:** write CLKDIV=4, then TXDATA=0xA5.
  - Line shows low for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles. The frame starts 1 cycle after the write ack.
- **Overflow:** with CLKDIV=100, write 10 bytes 0x00..0x09 back-to-back.
  - First byte pops immediately, 8 bytes fill the FIFO, the 10th is dropped.
  - STATUS shows FULL=1, OVF=1, level 8. Line emits 0x00..0x08 only.
- **OVF clear:** write STATUS with 0x8 → OVF=0. FULL is unchanged until the next pop.
- **Divisor edge and mid-frame write:** write CLKDIV=0 → reads back 1; a 0x55 frame is 10 cycles long. A CLKDIV write during a frame does not change that frame's bit width.
- **Reset mid-frame:** assert `rst_i` during DATA with 3 bytes queued → line high at once, STATUS=0x0000_0002 after release, and no further frames are sent.
